// File: rtl/rv32i_mul_dispatch.sv
// Issue/retire wrapper around the pipelined multiplier: tracks destination tags in issue order
// and presents a registered writeback beat. Optional hazard check enabled by RV32I_MUL_HAZARD_EN.
module rv32i_mul_dispatch #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  output logic        o_rdy,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd,
  output logic        m_vld,
  output logic [31:0] m_multiplicand,
  output logic [31:0] m_multiplier,
  input  logic        m_rdy,
  input  logic        m_res_vld,
  output logic        m_res_rdy,
  input  logic [31:0] m_product,
  output logic        o_wb_vld,
  input  logic        i_wb_rdy,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  input  logic [4:0]  i_chk_rd,
  output logic        o_rd_busy,
  output logic        o_err
);

  localparam int PW = $clog2(TAG_DEPTH);

  logic [4:0]    tag_mem_r [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          res_hs_s;
  logic          pop_s;
  logic          load_s;
  logic [4:0]    head_tag_s;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early.
  assign full_s     = (count_r == (PW+1)'(TAG_DEPTH));
  assign empty_s    = (count_r == {(PW+1){1'b0}});
  assign m_vld      = i_vld && !full_s;
  assign o_rdy      = m_rdy && !full_s;
  assign m_multiplicand = i_rs1;
  assign m_multiplier   = i_rs2;
  assign push_s     = m_vld && m_rdy;
  assign m_res_rdy  = !o_wb_vld || i_wb_rdy;
  assign res_hs_s   = m_res_vld && m_res_rdy;
  assign pop_s      = res_hs_s && !empty_s;
  assign head_tag_s = tag_mem_r[rd_ptr_r];
  assign load_s     = pop_s && (head_tag_s != 5'd0);

  // Tag queue storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_r[i] <= 5'd0;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= i_rd;
        wr_ptr_r            <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Writeback register and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wb_vld  <= 1'b0;
      o_wb_rd   <= 5'd0;
      o_wb_data <= 32'd0;
      o_err     <= 1'b0;
    end else begin
      if (load_s) begin
        o_wb_vld  <= 1'b1;
        o_wb_rd   <= head_tag_s;
        o_wb_data <= m_product;
      end else if (i_wb_rdy) begin
        o_wb_vld  <= 1'b0;
      end
      if (res_hs_s && empty_s) begin
        o_err <= 1'b1;
      end
    end
  end

`ifdef RV32I_MUL_HAZARD_EN
  logic match_s;

  // Compare the checked register against every occupied queue slot and the pending wb beat.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      if (((PW+1)'(i) < count_r) && (tag_mem_r[rd_ptr_r + PW'(i)] == i_chk_rd)) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
    if (o_wb_vld && (o_wb_rd == i_chk_rd)) begin
      match_s = 1'b1;
    end else begin
      match_s = match_s;
    end
  end

  assign o_rd_busy = (i_chk_rd != 5'd0) && match_s;
`else
  logic unused_chk_s;
  assign unused_chk_s = ^i_chk_rd;
  assign o_rd_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_mul_dispatch.sv
// Directed self-checking bench for rv32i_mul_dispatch; the bench plays the multiplier.
module tb_rv32i_mul_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd;
  logic        m_vld;
  logic [31:0] m_multiplicand;
  logic [31:0] m_multiplier;
  logic        m_rdy;
  logic        m_res_vld;
  logic        m_res_rdy;
  logic [31:0] m_product;
  logic        o_wb_vld;
  logic        i_wb_rdy;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic [4:0]  i_chk_rd;
  logic        o_rd_busy;
  logic        o_err;

  int n_cmp = 0;
  int n_bad = 0;

  rv32i_mul_dispatch #(.TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_rd(i_rd), .m_vld(m_vld), .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_rdy(m_rdy), .m_res_vld(m_res_vld), .m_res_rdy(m_res_rdy), .m_product(m_product),
    .o_wb_vld(o_wb_vld), .i_wb_rdy(i_wb_rdy), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .i_chk_rd(i_chk_rd), .o_rd_busy(o_rd_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    i_vld = 1'b1; i_rs1 = a; i_rs2 = b; i_rd = rd;
    #1;
    check_eq("issue_m_vld", m_vld, 1'b1);
    check_eq("issue_mcand", m_multiplicand, a);
    check_eq("issue_mplier", m_multiplier, b);
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic retire(input logic [31:0] p);
    @(negedge clk);
    m_res_vld = 1'b1; m_product = p;
    @(posedge clk); #1;
    m_res_vld = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_vld"}, o_wb_vld, 1'b1);
    check_eq({tag, "_rd"}, o_wb_rd, rd);
    check_eq({tag, "_data"}, o_wb_data, data);
  endtask

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_rd = 5'd0;
    m_rdy = 1'b1; m_res_vld = 1'b0; m_product = 32'd0; i_wb_rdy = 1'b1; i_chk_rd = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_wb_vld", o_wb_vld, 1'b0);
    check_eq("rst_wb_rd", o_wb_rd, 5'd0);
    check_eq("rst_wb_data", o_wb_data, 32'd0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_m_vld", m_vld, 1'b0);
    check_eq("rst_o_rdy", o_rdy, 1'b1);

    // Single op
    issue(32'h0000BEEF, 32'h000000CA, 5'd5);
    retire(32'h0096A896);
    check_wb("single", 5'd5, 32'h0096A896);
    @(posedge clk); #1;
    check_eq("single_vld_clr", o_wb_vld, 1'b0);
    check_eq("single_empty", dut.count_r, 3'd0);

    // Back-to-back ops, results delivered in issue order
    issue(32'h0000BEEF, 32'h000000CA, 5'd5);
    issue(32'h0000FEED, 32'h000000AC, 5'd6);
    retire(32'h0096A896);
    check_wb("b2b_first", 5'd5, 32'h0096A896);
    retire(32'h00AB473C);
    check_wb("b2b_second", 5'd6, 32'h00AB473C);
    @(posedge clk); #1;
    check_eq("b2b_vld_clr", o_wb_vld, 1'b0);

    // Full queue: fifth request blocked until the cycle after the first pop
    issue(32'd1, 32'd1, 5'd1);
    issue(32'd2, 32'd2, 5'd2);
    issue(32'd3, 32'd3, 5'd3);
    issue(32'd4, 32'd4, 5'd4);
    @(negedge clk);
    i_vld = 1'b1; i_rs1 = 32'd9; i_rs2 = 32'd9; i_rd = 5'd9;
    #1;
    check_eq("full_o_rdy", o_rdy, 1'b0);
    check_eq("full_m_vld", m_vld, 1'b0);
    @(negedge clk);
    m_res_vld = 1'b1; m_product = 32'd1;
    #1;
    check_eq("full_pop_o_rdy", o_rdy, 1'b0);
    @(posedge clk); #1;
    m_res_vld = 1'b0;
    check_wb("full_pop", 5'd1, 32'd1);
    @(negedge clk); #1;
    check_eq("full_after_o_rdy", o_rdy, 1'b1);
    check_eq("full_after_m_vld", m_vld, 1'b1);
    @(posedge clk); #1;
    i_vld = 1'b0;
    retire(32'd4);   check_wb("drain2", 5'd2, 32'd4);
    retire(32'd9);   check_wb("drain3", 5'd3, 32'd9);
    retire(32'd16);  check_wb("drain4", 5'd4, 32'd16);
    retire(32'd81);  check_wb("drain9", 5'd9, 32'd81);
    @(posedge clk); #1;
    check_eq("drain_empty", dut.count_r, 3'd0);

    // Backpressure: second result waits while wb is stalled
    issue(32'd10, 32'd10, 5'd10);
    issue(32'd11, 32'd11, 5'd11);
    @(negedge clk); i_wb_rdy = 1'b0;
    retire(32'hAAAA0001);
    check_wb("bp_first", 5'd10, 32'hAAAA0001);
    @(negedge clk);
    m_res_vld = 1'b1; m_product = 32'hBBBB0002;
    #1;
    check_eq("bp_res_rdy", m_res_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_wb("bp_hold", 5'd10, 32'hAAAA0001);
    end
    @(negedge clk); i_wb_rdy = 1'b1;
    #1;
    check_eq("bp_res_rdy_up", m_res_rdy, 1'b1);
    @(posedge clk); #1;
    m_res_vld = 1'b0;
    check_wb("bp_second", 5'd11, 32'hBBBB0002);
    @(posedge clk); #1;
    check_eq("bp_vld_clr", o_wb_vld, 1'b0);

    // rd=0 discards; spurious result sets sticky error
    issue(32'd2, 32'd3, 5'd0);
    retire(32'd6);
    check_eq("rd0_no_wb", o_wb_vld, 1'b0);
    check_eq("rd0_popped", dut.count_r, 3'd0);
    check_eq("rd0_no_err", o_err, 1'b0);
    retire(32'h12345678);
    check_eq("spur_err", o_err, 1'b1);
    check_eq("spur_no_wb", o_wb_vld, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("spur_err_sticky", o_err, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_err_clr", o_err, 1'b0);

    // Hazard check for an in-flight destination
    issue(32'd7, 32'd7, 5'd7);
    @(negedge clk); i_chk_rd = 5'd7; i_wb_rdy = 1'b0;
    #1;
`ifdef RV32I_MUL_HAZARD_EN
    check_eq("haz_queued", o_rd_busy, 1'b1);
`else
    check_eq("haz_off_queued", o_rd_busy, 1'b0);
`endif
    retire(32'd49);
`ifdef RV32I_MUL_HAZARD_EN
    check_eq("haz_wb_pending", o_rd_busy, 1'b1);
`else
    check_eq("haz_off_wb", o_rd_busy, 1'b0);
`endif
    @(negedge clk); i_wb_rdy = 1'b1;
    @(posedge clk); #1;
    check_eq("haz_released", o_rd_busy, 1'b0);
    issue(32'd1, 32'd1, 5'd0);
    @(negedge clk); i_chk_rd = 5'd0;
    #1;
    check_eq("haz_rd0", o_rd_busy, 1'b0);
    retire(32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
